net_packet_rx: RTL
==================

// Module: net_packet_rx
// PURPOSE
//  Core-side receiver for the boot/control network: samples one net_packet_s per cycle, filters on ID,
//  buffers accepted packets in a small FIFO, decodes net_op and drives the imem, regfile, PC and
//  barrier-mask write ports. Tracks the BOOT->RUN transition; sits between net_packet_flat_i and core datapath.
// PARAMETERS
//  CORE_ID      10'd1  packet ID this core accepts; all other IDs ignored
//  FIFO_DEPTH   4      packet buffer entries (power of 2, >=2)
//  IMEM_ADDR_W  10     instruction memory address width (net_addr[IMEM_ADDR_W-1:0])
// PORTS
//  clk              in   1                  clock
//  reset            in   1                  synchronous, active-low
//  net_packet_flat_i in  $bits(net_packet_s) incoming packet, held one cycle per packet
//  imem_ready_i     in   1                  imem write port free this cycle
//  imem_we_o        out  1                  instruction write strobe
//  imem_addr_o      out  IMEM_ADDR_W        instruction address
//  imem_data_o      out  16                 instruction_s (net_data[15:0])
//  rf_we_o          out  1                  register write strobe
//  rf_addr_o        out  rs_imm_size_gp     register index (net_addr[5:0])
//  rf_data_o        out  32                 register value
//  pc_we_o          out  1                  PC load strobe
//  pc_o             out  32                 PC value (net_data)
//  barrier_mask_o   out  mask_length_gp     barrier mask register
//  run_o            out  1                  core released from boot
//  overflow_o       out  1                  sticky: packet dropped on full FIFO
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FIFO flushed, state BOOT, every output 0. Mid-operation reset discards
//    buffered packets and pending strobes that cycle.
//  - Accept: net_op!=NULL && ID==CORE_ID -> push. NULL or foreign ID: ignored, not counted.
//  - Full FIFO: push allowed only if a pop occurs same cycle; otherwise packet dropped, overflow_o<=1.
//  - Empty FIFO: push and pop never the same cycle (no bypass). Packet sampled at edge k -> strobe high
//    in cycle after edge k+1 (2-cycle latency).
//  - Pop/decode of FIFO head, at most one packet per cycle; all strobes are registered 1-cycle pulses:
//    INSTR: pops only when imem_ready_i==1; else head stalls, FIFO keeps filling. imem_we_o pulse.
//    REG:   pops unconditionally; rf_we_o pulse. Address taken from net_addr[rs_imm_size_gp-1:0].
//    BAR:   barrier_mask_o <= net_data[mask_length_gp-1:0]; held until next BAR or reset.
//    PC:    pc_we_o pulse, pc_o<=net_data; state BOOT->RUN, run_o<=1 same edge as pc_we_o.
//  - FSM BOOT: all ops decoded. RUN: BAR and PC decoded (PC reloads PC, stays RUN); INSTR/REG popped
//    and discarded (no strobe). RUN->BOOT only by reset.
//  - Strobes mutually exclusive; data outputs hold last value when strobe low.
//  - FIFO pointers log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full/empty by MSB compare.
// CONFIGURATION
//  NET_RX_STATS_EN defined: adds outputs pkt_count_o[31:0] (accepted packets pushed) and drop_count_o[15:0]
//   (overflow drops + RUN-discarded INSTR/REG); both reset to 0, saturate at all-ones.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset held 2 cycles with INSTR traffic -> all outputs 0, no strobes, run_o=0.
//  2 INSTR addr 3 data 16'h1A2B, imem_ready_i=1 -> imem_we_o pulse 2 cycles later, addr 3, data 16'h1A2B.
//  3 imem_ready_i=0, 6 back-to-back INSTR (DEPTH 4) -> 4 stored, 2 dropped, overflow_o=1; ready=1 -> 4 writes in order.
//  4 REG addr 6'd5 data 32'hDEADBEEF then BAR 32'h2 -> rf_we_o addr 5; barrier_mask_o=2 thereafter.
//  5 PC data 32'h5 -> pc_we_o pulse, pc_o=5, run_o=1; next REG -> no rf_we_o (drop_count_o +1 if STATS_EN).
//  6 Packet ID 10'd2 and NULL op -> no strobes, FIFO empty, counters unchanged.

Source files
------------

// File: rtl/net_packet_rx.sv
// Boot/control network receiver: ID filter, small packet FIFO, op decode driving imem/regfile/PC/barrier ports.
// Optional NET_RX_STATS_EN adds saturating accepted-packet and drop counters.

package net_rx_pkg;
   localparam int rs_imm_size_gp = 6;
   localparam int mask_length_gp = 16;

   typedef enum logic [2:0] {
      NET_OP_NULL  = 3'd0,
      NET_OP_INSTR = 3'd1,
      NET_OP_REG   = 3'd2,
      NET_OP_BAR   = 3'd3,
      NET_OP_PC    = 3'd4
   } net_op_e;

   typedef struct packed {
      logic [9:0]  net_id;
      net_op_e     net_op;
      logic [15:0] net_addr;
      logic [31:0] net_data;
   } net_packet_s;
endpackage

module net_packet_rx
   import net_rx_pkg::*;
#(
   parameter logic [9:0] CORE_ID     = 10'd1,
   parameter int         FIFO_DEPTH  = 4,
   parameter int         IMEM_ADDR_W = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [$bits(net_packet_s)-1:0] net_packet_flat_i,
   input  logic                         imem_ready_i,
   output logic                         imem_we_o,
   output logic [IMEM_ADDR_W-1:0]       imem_addr_o,
   output logic [15:0]                  imem_data_o,
   output logic                         rf_we_o,
   output logic [rs_imm_size_gp-1:0]    rf_addr_o,
   output logic [31:0]                  rf_data_o,
   output logic                         pc_we_o,
   output logic [31:0]                  pc_o,
   output logic [mask_length_gp-1:0]    barrier_mask_o,
   output logic                         run_o,
`ifdef NET_RX_STATS_EN
   output logic [31:0]                  pkt_count_o,
   output logic [15:0]                  drop_count_o,
`endif
   output logic                         overflow_o
);

   localparam int IDX_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W = IDX_W + 1;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } rx_state_e;

   rx_state_e state, next_state;

   net_packet_s in_pkt;
   net_packet_s head;
   net_packet_s fifo_mem [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic fifo_empty, fifo_full;
   logic accept, push, pop, drop;
   logic do_instr, do_reg, do_bar, do_pc, discard;
   logic unused_head_bits;

   assign in_pkt     = net_packet_s'(net_packet_flat_i);
   assign head       = fifo_mem[rd_ptr[IDX_W-1:0]];
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

   assign accept = (in_pkt.net_op != NET_OP_NULL) && (in_pkt.net_id == CORE_ID);
   // A full FIFO still takes a packet when the head leaves on the same edge.
   assign push   = accept && (!fifo_full || pop);
   assign drop   = accept && fifo_full && !pop;

   assign unused_head_bits = ^{head.net_id, head.net_addr, head.net_data};

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_BOOT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      do_instr   = 1'b0;
      do_reg     = 1'b0;
      do_bar     = 1'b0;
      do_pc      = 1'b0;
      discard    = 1'b0;
      if (!fifo_empty) begin
         case (head.net_op)
            NET_OP_INSTR: begin
               if (state == ST_RUN) begin
                  pop     = 1'b1;
                  discard = 1'b1;
               end else if (imem_ready_i) begin
                  pop      = 1'b1;
                  do_instr = 1'b1;
               end
            end
            NET_OP_REG: begin
               pop = 1'b1;
               if (state == ST_RUN) begin
                  discard = 1'b1;
               end else begin
                  do_reg = 1'b1;
               end
            end
            NET_OP_BAR: begin
               pop    = 1'b1;
               do_bar = 1'b1;
            end
            NET_OP_PC: begin
               pop        = 1'b1;
               do_pc      = 1'b1;
               next_state = ST_RUN;
            end
            default: begin
               pop = 1'b1;
            end
         endcase
      end
   end

   // Storage needs no reset; the pointer flush makes stale entries invisible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[IDX_W-1:0]] <= in_pkt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         imem_we_o      <= 1'b0;
         imem_addr_o    <= '0;
         imem_data_o    <= '0;
         rf_we_o        <= 1'b0;
         rf_addr_o      <= '0;
         rf_data_o      <= '0;
         pc_we_o        <= 1'b0;
         pc_o           <= '0;
         barrier_mask_o <= '0;
         run_o          <= 1'b0;
         overflow_o     <= 1'b0;
      end else begin
         imem_we_o <= do_instr;
         rf_we_o   <= do_reg;
         pc_we_o   <= do_pc;
         run_o     <= (next_state == ST_RUN);
         if (do_instr) begin
            imem_addr_o <= head.net_addr[IMEM_ADDR_W-1:0];
            imem_data_o <= head.net_data[15:0];
         end
         if (do_reg) begin
            rf_addr_o <= head.net_addr[rs_imm_size_gp-1:0];
            rf_data_o <= head.net_data;
         end
         if (do_bar) begin
            barrier_mask_o <= head.net_data[mask_length_gp-1:0];
         end
         if (do_pc) begin
            pc_o <= head.net_data;
         end
         if (drop) begin
            overflow_o <= 1'b1;
         end
      end
   end

`ifdef NET_RX_STATS_EN
   logic [1:0]  drop_inc;
   logic [16:0] drop_sum;

   assign drop_inc = {1'b0, drop} + {1'b0, discard};
   assign drop_sum = {1'b0, drop_count_o} + {15'd0, drop_inc};

   // Both counters stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pkt_count_o  <= '0;
         drop_count_o <= '0;
      end else begin
         if (push && !(&pkt_count_o)) begin
            pkt_count_o <= pkt_count_o + 32'd1;
         end
         drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end
`endif

endmodule
